sar_adc_seq: RTL

Multi-channel SAR ADC sequencer: a parametrised successor to the single-channel SAR controller. It latches a channel mask and scans every enabled channel in ascending order, with a configurable sample phase per channel. It runs single-shot or continuous scans and delivers each tagged result over a valid/ready handshake with overrun detection. It sits between the analog front-end (input mux, capacitive DAC, differential comparator) and the digital consumer.

---
 rtl/sar_adc_seq_pkg.sv | 38 +++
 rtl/sar_adc_seq_ch_pick.sv | 31 +++
 rtl/sar_adc_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_seq_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC sequencer.
// Channel-search helpers work on a fixed 64-bit mask, so up to 32 channels are supported.
package sar_adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int PICK_MAX_W = 64;
    localparam int PICK_IDX_W = 6;

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lowest set bit strictly above idx.
    function automatic pick_t lowest_above(input logic [PICK_MAX_W-1:0] mask, input int idx);
        pick_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = PICK_MAX_W - 1; i >= 0; i--) begin
            if (mask[i] && (i > idx)) begin
                r.found = 1'b1;
                r.idx   = PICK_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sar_adc_seq_ch_pick.sv
// Next-channel finder: searches {new mask, current mask} above the current channel, so one
// lookup covers both "next channel of this scan" and "first channel of a restarted scan".
module sar_ch_pick
    import sar_adc_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_W         = ch_w(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] i_mask_cur,
    input  logic [NUM_CHANNELS-1:0] i_mask_new,
    input  logic [CH_W-1:0]         i_cur,
    output logic                    o_found,
    output logic                    o_wrap,
    output logic [CH_W-1:0]         o_ch
);

    logic [PICK_MAX_W-1:0] w_ext;
    pick_t                 w_pick;
    logic [PICK_IDX_W-1:0] w_idx_adj;

    always_comb begin
        w_ext = '0;
        w_ext[2*NUM_CHANNELS-1:0] = {i_mask_new, i_mask_cur};
        w_pick = lowest_above(w_ext, int'(i_cur));
        o_found = w_pick.found;
        o_wrap  = (w_pick.idx >= PICK_IDX_W'(NUM_CHANNELS));
        w_idx_adj = o_wrap ? (w_pick.idx - PICK_IDX_W'(NUM_CHANNELS)) : w_pick.idx;
        o_ch = CH_W'(w_idx_adj);
    end

endmodule

// File: rtl/sar_adc_seq.sv
// Multi-channel SAR ADC sequencer with valid/ready result delivery and overrun flag.
// Optional comparator consistency check: define SAR_ADC_SEQ_COMP_CHECK_EN.
//   state   | meaning
//   IDLE    | waiting for start_i with a non-zero mask
//   SAMPLE  | sample switch closed on ch_sel_o for SAMPLE_CYCLES cycles
//   CONVERT | one bit decided per cycle, MSB first
//   DONE    | result loaded, pick next channel / restart / stop
module sar_adc_seq
    import sar_adc_seq_pkg::*;
#(
    parameter int RESOLUTION    = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int CH_W          = ch_w(NUM_CHANNELS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    cont_i,
    input  logic [NUM_CHANNELS-1:0] ch_mask_i,
    input  logic                    comp_p_i,
    input  logic                    comp_n_i,
    output logic                    sample_o,
    output logic [CH_W-1:0]         ch_sel_o,
    output logic [RESOLUTION-1:0]   dac_p_o,
    output logic [RESOLUTION-1:0]   dac_n_o,
    output logic                    busy_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [RESOLUTION-1:0]   result_o,
    output logic [CH_W-1:0]         result_ch_o,
    output logic                    overrun_o,
    output logic                    comp_err_o
);

    localparam int BIT_W = $clog2(RESOLUTION);
    localparam int CNT_W = (SAMPLE_CYCLES <= 1) ? 1 : $clog2(SAMPLE_CYCLES);

    state_t                  r_state;
    logic [NUM_CHANNELS-1:0] r_mask;
    logic [CH_W-1:0]         r_ch;
    logic [CNT_W-1:0]        r_cnt;
    logic [BIT_W-1:0]        r_bit;
    logic [RESOLUTION-1:0]   r_dac;
    logic                    r_sample;
    logic [RESOLUTION-1:0]   r_result;
    logic [CH_W-1:0]         r_result_ch;
    logic                    r_valid;
    logic                    r_overrun;
    logic                    r_comp_err;

    logic                    w_restart;
    logic [NUM_CHANNELS-1:0] w_pick_cur;
    logic [NUM_CHANNELS-1:0] w_pick_new;
    logic                    w_found;
    logic                    w_wrap;
    logic [CH_W-1:0]         w_pick_ch;
    logic                    w_decision;
    logic                    w_invalid;

`ifdef SAR_ADC_SEQ_COMP_CHECK_EN
    assign w_invalid  = (comp_p_i == comp_n_i);
    assign w_decision = comp_p_i & ~w_invalid;
`else
    logic w_unused_comp_n;
    assign w_unused_comp_n = comp_n_i;
    assign w_invalid  = 1'b0;
    assign w_decision = comp_p_i;
`endif

    assign w_restart  = cont_i | start_i;
    assign w_pick_cur = (r_state == DONE) ? r_mask : '0;
    assign w_pick_new = (((r_state == IDLE) && start_i) || ((r_state == DONE) && w_restart))
                        ? ch_mask_i : '0;

    sar_ch_pick #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_W         (CH_W)
    ) u_pick (
        .i_mask_cur (w_pick_cur),
        .i_mask_new (w_pick_new),
        .i_cur      (r_ch),
        .o_found    (w_found),
        .o_wrap     (w_wrap),
        .o_ch       (w_pick_ch)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_ch        <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_dac       <= '0;
            r_sample    <= 1'b0;
            r_result    <= '0;
            r_result_ch <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_comp_err  <= 1'b0;
        end else begin
            // A DONE load below overrides this, so the new result wins over a transfer.
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_mask     <= ch_mask_i;
                        r_ch       <= w_pick_ch;
                        r_overrun  <= 1'b0;
                        r_comp_err <= 1'b0;
                        r_cnt      <= CNT_W'(SAMPLE_CYCLES - 1);
                        r_sample   <= 1'b1;
                        r_state    <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (r_cnt == '0) begin
                        r_sample <= 1'b0;
                        r_dac    <= {1'b1, {(RESOLUTION-1){1'b0}}};
                        r_bit    <= BIT_W'(RESOLUTION - 1);
                        r_state  <= CONVERT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                CONVERT: begin
                    r_dac[r_bit] <= w_decision;
                    if (w_invalid) begin
                        r_comp_err <= 1'b1;
                    end
                    if (r_bit == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_dac[r_bit - BIT_W'(1)] <= 1'b1;
                        r_bit <= r_bit - BIT_W'(1);
                    end
                end
                DONE: begin
                    r_result    <= r_dac;
                    r_result_ch <= r_ch;
                    r_valid     <= 1'b1;
                    r_dac       <= '0;
                    if (r_valid && !ready_i) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_found) begin
                        if (w_wrap) begin
                            r_mask <= ch_mask_i;
                        end
                        r_ch     <= w_pick_ch;
                        r_cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
                        r_sample <= 1'b1;
                        r_state  <= SAMPLE;
                    end else begin
                        if (w_restart) begin
                            r_mask <= ch_mask_i;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sample_o    = r_sample;
    assign ch_sel_o    = r_ch;
    assign dac_p_o     = r_dac;
    assign dac_n_o     = ~r_dac;
    assign busy_o      = (r_state != IDLE);
    assign valid_o     = r_valid;
    assign result_o    = r_result;
    assign result_ch_o = r_result_ch;
    assign overrun_o   = r_overrun;
    assign comp_err_o  = r_comp_err;

endmodule
